// File: rtl/lift_controller_indicator.sv
// Lift controller: SCAN request service, travel/door timers,
// and a 7-segment digit for the current floor.
module lift_controller_indicator #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    floor,
  output logic [6:0]            seg,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  localparam logic [15:0] TT_LAST = 16'(TRAVEL_CYCLES - 1);
  localparam logic [15:0] DC_LAST = 16'(DOOR_CYCLES - 1);

  state_t                  state, state_nx;
  logic [FLOOR_W-1:0]      floor_nx, step_fl;
  logic [NUM_FLOORS-1:0]   pending_nx, clr, pn;
  logic [NUM_FLOORS-1:0]   cur_oh, nxt_oh;
  logic                    last_dir, last_dir_nx;
  logic [15:0]             ttmr, ttmr_nx;
  logic [15:0]             dtmr, dtmr_nx;
  logic                    above, below;
  logic                    go_up, go_dn;

  // Sweep decision: keep direction while work remains ahead, else reverse
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(floor))) above = 1'b1;
      if (pending[i] && (i < int'(floor))) below = 1'b1;
    end
    go_up   = above && (last_dir || !below);
    go_dn   = below && (!last_dir || !above);
    pn      = pending | req;
    cur_oh  = NUM_FLOORS'(1) << floor;
    step_fl = last_dir ? floor + FLOOR_W'(1)
                       : floor - FLOOR_W'(1);
    nxt_oh  = NUM_FLOORS'(1) << step_fl;
  end

  // Next-state, timers, floor step and served-floor clear
  always_comb begin
    state_nx    = state;
    floor_nx    = floor;
    last_dir_nx = last_dir;
    ttmr_nx     = ttmr;
    dtmr_nx     = dtmr;
    clr         = '0;
    unique case (state)
      IDLE: begin
        if (|(pn & cur_oh)) begin
          state_nx = DOOR;
          clr      = cur_oh;
          dtmr_nx  = '0;
        end else if (go_up || go_dn) begin
          state_nx    = MOVE;
          last_dir_nx = go_up;
          ttmr_nx     = '0;
        end
      end
      MOVE: begin
        if (ttmr != TT_LAST) begin
          ttmr_nx = ttmr + 16'd1;
        end else begin
          floor_nx = step_fl;
          ttmr_nx  = '0;
          if (|(pn & nxt_oh)) begin
            state_nx = DOOR;
            clr      = nxt_oh;
            dtmr_nx  = '0;
          end
        end
      end
      DOOR: begin
        clr = cur_oh;
        if (|(req & cur_oh)) begin
          dtmr_nx = '0;
        end else if (dtmr != DC_LAST) begin
          dtmr_nx = dtmr + 16'd1;
        end else if (go_up || go_dn) begin
          state_nx    = MOVE;
          last_dir_nx = go_up;
          ttmr_nx     = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    pending_nx = pn & ~clr;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor    <= '0;
      pending  <= '0;
      last_dir <= 1'b1;
      ttmr     <= '0;
      dtmr     <= '0;
    end else begin
      state    <= state_nx;
      floor    <= floor_nx;
      pending  <= pending_nx;
      last_dir <= last_dir_nx;
      ttmr     <= ttmr_nx;
      dtmr     <= dtmr_nx;
    end
  end

  // Status flags derived from the registered state
  always_comb begin
    dir_up    = (state == MOVE) && last_dir;
    dir_down  = (state == MOVE) && !last_dir;
    door_open = (state == DOOR);
  end

  // Floor digit decode, {a,b,c,d,e,f,g}
  always_comb begin
    seg = 7'b0000000;
    case (int'(floor))
      0: seg = 7'b1111110;
      1: seg = 7'b0110000;
      2: seg = 7'b1101101;
      3: seg = 7'b1111001;
      4: seg = 7'b0110011;
      5: seg = 7'b1011011;
      6: seg = 7'b1011111;
      7: seg = 7'b1110000;
      8: seg = 7'b1111111;
      9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

endmodule
